// File: rtl/dc_rr_arbiter.sv
// dc_rr_arbiter: four-way round-robin arbiter for a shared datapath.
//
// The owner keeps the grant while it keeps requesting. If another requester
// is waiting and the owner has already held the grant for HOLD_MAX cycles,
// the grant is taken away and passed on. The winning index is expanded to a
// one-hot grant by the 2-to-4 enable decoder dc.
//
// Ports
//   iclk    in   1  clock, rising edge
//   irst_n  in   1  synchronous reset, active-low
//   ien     in   1  arbitration enable (gates new grants, handoff and preempt)
//   ireq    in   4  request vector, bit k = requester k
//   ogrant  out  4  one-hot grant, zero when idle
//   oidx    out  2  current owner index, 0 when idle
//   ovalid  out  1  a grant is active
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; the next enabled request wins in round-robin order
// GRANT | idx_q owns the resource; hcnt_q counts its cycles of ownership

// 2-to-4 enable decoder: oy is one-hot at position ia when is=1, else 0.
module dc (
  input  logic [1:0] ia,
  input  logic       is,
  output logic [3:0] oy
);
  assign oy = is ? (4'b0001 << ia) : 4'b0000;
endmodule

module dc_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       ien,
  input  logic [3:0] ireq,
  output logic [3:0] ogrant,
  output logic [1:0] oidx,
  output logic       ovalid
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hcnt_q, hcnt_d;

  logic [3:0] others;
  logic [2:0] pick_idle;
  logic [2:0] pick_hand;

  // Returns {found, index} of the first set bit searching base+1, base+2,
  // base+3, base (mod 4).
  function automatic logic [2:0] rr_pick(input logic [1:0] base,
                                         input logic [3:0] req);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (req[cand] && !res[2]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  // Handoff never returns the grant to the current owner, so its own bit is
  // masked out before searching.
  assign others    = ireq & ~(4'b0001 << idx_q);
  assign pick_idle = rr_pick(last_q, ireq);
  assign pick_hand = rr_pick(idx_q, others);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      IDLE: begin
        if (ien && pick_idle[2]) begin
          state_d = GRANT;
          idx_d   = pick_idle[1:0];
          last_d  = pick_idle[1:0];
          hcnt_d  = 8'd0;
        end
      end
      GRANT: begin
        if (!ireq[idx_q]) begin
          if (ien && pick_hand[2]) begin
            idx_d  = pick_hand[1:0];
            last_d = pick_hand[1:0];
            hcnt_d = 8'd0;
          end else begin
            state_d = IDLE;
            idx_d   = 2'd0;
            hcnt_d  = 8'd0;
          end
        end else if (hcnt_q == HOLD_LAST && ien && pick_hand[2]) begin
          idx_d  = pick_hand[1:0];
          last_d = pick_hand[1:0];
          hcnt_d = 8'd0;
        end else if (hcnt_q != HOLD_LAST) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        hcnt_d  = 8'd0;
      end
    endcase
  end

  // last resets to 3 so requester 0 is first in line after reset.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
      hcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign ovalid = (state_q == GRANT);
  assign oidx   = idx_q;

  dc u_dc (
    .ia (idx_q),
    .is (ovalid),
    .oy (ogrant)
  );

endmodule

// File: tb/tb_dc_rr_arbiter.sv
module tb_dc_rr_arbiter;

  logic       iclk;
  logic       irst_n;
  logic       ien;
  logic [3:0] ireq;
  logic [3:0] ogrant;
  logic [1:0] oidx;
  logic       ovalid;

  int checks   = 0;
  int failures = 0;

  dc_rr_arbiter #(.HOLD_MAX(8)) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .ien    (ien),
    .ireq   (ireq),
    .ogrant (ogrant),
    .oidx   (oidx),
    .ovalid (ovalid)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [3:0] q,
                              logic [3:0] g, logic [1:0] i, logic v, string n);
    vec_t t;
    t.rst_n = r; t.en = e; t.req = q; t.grant = g; t.idx = i; t.valid = v; t.name = n;
    return t;
  endfunction

  // Apply inputs, clock one edge, sample #1 after it.
  task automatic step(input logic r, input logic e, input logic [3:0] q);
    irst_n = r;
    ien    = e;
    ireq   = q;
    @(posedge iclk);
    #1;
  endtask

  task automatic check_out(input string n, input logic [3:0] g,
                           input logic [1:0] i, input logic v);
    checks++;
    if (ogrant !== g || oidx !== i || ovalid !== v) begin
      failures++;
      $display("FAIL %s: got grant=%b idx=%0d valid=%b, expected grant=%b idx=%0d valid=%b",
               n, ogrant, oidx, ovalid, g, i, v);
    end
  endtask

  initial begin
    irst_n = 1'b0;
    ien    = 1'b1;
    ireq   = 4'b0000;

    // single request
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, "reset"));
    vecs.push_back(mk(1, 1, 4'b0100, 4'b0100, 2, 1, "single_grant"));
    vecs.push_back(mk(1, 1, 4'b0100, 4'b0100, 2, 1, "single_hold"));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, "single_release"));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, "idle_stay"));
    // fairness 0,1,2,3,0 with no idle cycles
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, "fair_reset"));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b0001, 0, 1, "fair_g0a"));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b0001, 0, 1, "fair_g0b"));
    vecs.push_back(mk(1, 1, 4'b1110, 4'b0010, 1, 1, "fair_g1a"));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b0010, 1, 1, "fair_g1b"));
    vecs.push_back(mk(1, 1, 4'b1101, 4'b0100, 2, 1, "fair_g2a"));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b0100, 2, 1, "fair_g2b"));
    vecs.push_back(mk(1, 1, 4'b1011, 4'b1000, 3, 1, "fair_g3a"));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b1000, 3, 1, "fair_g3b"));
    vecs.push_back(mk(1, 1, 4'b0111, 4'b0001, 0, 1, "fair_wrap0"));
    // reset mid-grant
    vecs.push_back(mk(1, 1, 4'b1110, 4'b0010, 1, 1, "mid_g1"));
    vecs.push_back(mk(1, 1, 4'b1101, 4'b0100, 2, 1, "mid_g2"));
    vecs.push_back(mk(0, 1, 4'b1111, 4'b0000, 0, 0, "mid_reset"));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b0001, 0, 1, "mid_after_reset"));
    // enable gating in IDLE
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, "en_reset"));
    vecs.push_back(mk(1, 0, 4'b0010, 4'b0000, 0, 0, "en_off_a"));
    vecs.push_back(mk(1, 0, 4'b0010, 4'b0000, 0, 0, "en_off_b"));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b0010, 1, 1, "en_on_grant"));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].req);
      check_out(vecs[i].name, vecs[i].grant, vecs[i].idx, vecs[i].valid);
    end

    // ien=0 with contention: no preemption of requester 1 for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 4'b0011);
      check_out("en_nopreempt", 4'b0010, 1, 1);
    end
    // re-enable: hold count is saturated, so preempt happens at once
    step(1, 1, 4'b0011);
    check_out("en_preempt", 4'b0001, 0, 1);
    // release with ien=0 goes idle even though requester 1 waits
    step(1, 0, 4'b0010);
    check_out("en_release_idle", 4'b0000, 0, 0);

    // preemption: 8 cycles each, alternating
    step(0, 1, 4'b0000);
    check_out("pre_reset", 4'b0000, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(1, 1, 4'b0011);
      if (((i / 8) % 2) == 0) check_out("preempt", 4'b0001, 0, 1);
      else                    check_out("preempt", 4'b0010, 1, 1);
    end

    // lone holder keeps the grant; hold counter saturates
    step(0, 1, 4'b0000);
    check_out("lone_reset", 4'b0000, 0, 0);
    for (int i = 0; i < 50; i++) begin
      step(1, 1, 4'b1000);
      check_out("lone_hold", 4'b1000, 3, 1);
    end
    checks++;
    if (dut.hcnt_q !== 8'd7) begin
      failures++;
      $display("FAIL lone_hcnt: got %0d expected 7", dut.hcnt_q);
    end
    step(1, 1, 4'b1001);
    check_out("lone_handoff", 4'b0001, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Grant must be one-hot or zero and consistent with idx/valid at every sample.
  always @(negedge iclk) begin
    if (irst_n === 1'b1 || irst_n === 1'b0) begin
      if (!$onehot0(ogrant) || (ovalid && ogrant !== (4'b0001 << oidx)) ||
          (!ovalid && (ogrant !== 4'b0000 || oidx !== 2'd0))) begin
        checks++;
        failures++;
        $display("FAIL grant_consistency: got grant=%b idx=%0d valid=%b", ogrant, oidx, ovalid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
